// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: oversample, mid-bit and bit-boundary strobes from a runtime divisor.
// Define BAUD_FRAC_EN to build the fractional divisor accumulator; otherwise the period is the integer divisor only.
module baud_tick_gen #(
  parameter int unsigned DIV_W            = 16,
  parameter int unsigned FRAC_W           = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 651,
  parameter int unsigned DEFAULT_DIV_FRAC = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          resync,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [DIV_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] MID_PH  = PH_W'(OVERSAMPLE/2 - 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] sh_int_q, sh_int_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;

  logic             carry;
  logic [DIV_W-1:0] eff_int;
  logic [DIV_W:0]   len;
  logic             last;
  logic             swap;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   frac_sum;

  // acc and act_frac only change at a period boundary (or while frozen/resynced),
  // so evaluating the carry every cycle equals evaluating it at period start.
  assign frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
  assign carry    = frac_sum[FRAC_W];
`else
  logic unused_frac;
  assign unused_frac = ^{cfg_div_frac, FRAC_W'(DEFAULT_DIV_FRAC)};
  assign carry       = 1'b0;
`endif

  assign eff_int = (act_int_q == '0) ? DIV_W'(1) : act_int_q;
  assign len     = {1'b0, eff_int} + (DIV_W+1)'(carry);
  assign last    = ({1'b0, cnt_q} == (len - (DIV_W+1)'(1)));
  assign swap    = pending_q && (resync || !en || last);

  always_comb begin
    act_int_d  = act_int_q;
    sh_int_d   = sh_int_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
`ifdef BAUD_FRAC_EN
    act_frac_d = act_frac_q;
    sh_frac_d  = sh_frac_q;
    acc_d      = acc_q;
`endif

    if (resync) begin
      cnt_d   = '0;
      phase_d = '0;
`ifdef BAUD_FRAC_EN
      acc_d   = '0;
`endif
    end else if (en) begin
      if (last) begin
        cnt_d      = '0;
        phase_d    = phase_q + PH_W'(1);
        os_tick_d  = 1'b1;
        mid_tick_d = (phase_q == MID_PH);
        bit_tick_d = (phase_q == LAST_PH);
`ifdef BAUD_FRAC_EN
        acc_d      = frac_sum[FRAC_W-1:0];
`endif
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // A swap only happens with pending set, so it never coincides with an accept.
    if (swap) begin
      act_int_d  = sh_int_q;
      pending_d  = 1'b0;
`ifdef BAUD_FRAC_EN
      act_frac_d = sh_frac_q;
`endif
    end else if (cfg_valid && !pending_q) begin
      sh_int_d   = cfg_div_int;
      pending_d  = 1'b1;
`ifdef BAUD_FRAC_EN
      sh_frac_d  = cfg_div_frac;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_int_q  <= DIV_W'(DEFAULT_DIV_INT);
      sh_int_q   <= '0;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
`ifdef BAUD_FRAC_EN
      act_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
      sh_frac_q  <= '0;
      acc_q      <= '0;
`endif
    end else begin
      act_int_q  <= act_int_d;
      sh_int_q   <= sh_int_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
`ifdef BAUD_FRAC_EN
      act_frac_q <= act_frac_d;
      sh_frac_q  <= sh_frac_d;
      acc_q      <= acc_d;
`endif
    end
  end

  assign cfg_ready = ~pending_q;
  assign os_tick   = os_tick_q;
  assign mid_tick  = mid_tick_q;
  assign bit_tick  = bit_tick_q;
  assign os_phase  = phase_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed testbench for baud_tick_gen; expected values are hand-computed per step.
// Fractional expectations follow BAUD_FRAC_EN when it is defined for the build.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset, en, resync, cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        os_tick, mid_tick, bit_tick;
  logic [3:0]  os_phase;

  int checks = 0;
  int errors = 0;

  baud_tick_gen #(
    .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16),
    .DEFAULT_DIV_INT(651), .DEFAULT_DIV_FRAC(1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .resync(resync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .os_phase(os_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges until os_tick is seen, bounded so a dead DUT still reaches the summary.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (os_tick !== 1'b1 && n < 3000);
  endtask

  task automatic load_frozen(input int div_i, input int div_f);
    en = 1'b0;
    cfg_valid = 1'b1; cfg_div_int = 16'(div_i); cfg_div_frac = 4'(div_f);
    tick();
    cfg_valid = 1'b0;
    tick();
  endtask

  initial begin
    int n, total, os_cnt, mid_cnt, bit_cnt, first_at, mid_at, bit_at, ph20;
    int exp_p2, exp_total;
`ifdef BAUD_FRAC_EN
    exp_p2 = 5; exp_total = 72;
`else
    exp_p2 = 4; exp_total = 64;
`endif
    reset = 1'b1; en = 1'b0; resync = 1'b0; cfg_valid = 1'b0;
    cfg_div_int = '0; cfg_div_frac = '0;
    tick(); tick();
    check("rst_os_tick", os_tick, 0);
    check("rst_mid_tick", mid_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_phase", os_phase, 0);
    check("rst_ready", cfg_ready, 1);

    reset = 1'b0;
    cfg_valid = 1'b1; cfg_div_int = 16'd4; cfg_div_frac = 4'd0;
    tick();
    check("cfg_ready_fall", cfg_ready, 0);
    cfg_valid = 1'b0;
    tick();
    check("cfg_ready_swap_frozen", cfg_ready, 1);

    // integer divide by 4
    en = 1'b1;
    os_cnt = 0; mid_cnt = 0; bit_cnt = 0; first_at = 0; mid_at = 0; bit_at = 0; ph20 = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (os_tick === 1'b1) begin
        os_cnt++;
        if (first_at == 0) first_at = i;
      end
      if (mid_tick === 1'b1) begin mid_cnt++; mid_at = i; end
      if (bit_tick === 1'b1) begin bit_cnt++; bit_at = i; end
      if (i == 20) ph20 = int'(os_phase);
    end
    check("int_first_os", first_at, 4);
    check("int_os_count", os_cnt, 16);
    check("int_phase_at20", ph20, 5);
    check("int_mid_count", mid_cnt, 1);
    check("int_mid_at", mid_at, 32);
    check("int_bit_count", bit_cnt, 1);
    check("int_bit_at", bit_at, 64);
    check("int_phase_wrap", os_phase, 0);

    // fractional divide 4 + 8/16
    load_frozen(4, 8);
    en = 1'b1;
    wait_tick(n);
    check("frac_p1", n, 4);
    total = n;
    wait_tick(n);
    check("frac_p2", n, exp_p2);
    total += n;
    for (int k = 0; k < 14; k++) begin
      wait_tick(n);
      total += n;
    end
    check("frac_total16", total, exp_total);
    check("frac_bit_tick", bit_tick, 1);

    // enable freeze mid-period
    load_frozen(4, 0);
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    repeat (10) tick();
    check("freeze_os_tick", os_tick, 0);
    check("freeze_phase", os_phase, 0);
    en = 1'b1;
    wait_tick(n);
    check("freeze_remaining", n, 2);
    check("freeze_phase_after", os_phase, 1);

    // resync on a period-end cycle
    tick(); tick(); tick();
    check("pre_resync_os", os_tick, 0);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("resync_os_tick", os_tick, 0);
    check("resync_phase", os_phase, 0);
    wait_tick(n);
    check("resync_period", n, 4);
    check("resync_phase_after", os_phase, 1);

    // handshake while running
    tick();
    cfg_valid = 1'b1; cfg_div_int = 16'd6;
    tick();
    check("hs_ready_low", cfg_ready, 0);
    cfg_div_int = 16'd9;
    wait_tick(n);
    check("hs_old_period_end", n, 2);
    check("hs_ready_after_swap", cfg_ready, 1);
    tick();
    check("hs_second_accepted", cfg_ready, 0);
    cfg_valid = 1'b0;
    wait_tick(n);
    check("hs_period6_rest", n, 5);
    check("hs_ready_after_swap2", cfg_ready, 1);
    wait_tick(n);
    check("hs_period9", n, 9);

    // reset mid-handshake discards pending divisor
    tick(); tick();
    cfg_valid = 1'b1; cfg_div_int = 16'd3;
    tick();
    check("rst2_pending", cfg_ready, 0);
    cfg_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("rst2_os_tick", os_tick, 0);
    check("rst2_mid_tick", mid_tick, 0);
    check("rst2_bit_tick", bit_tick, 0);
    check("rst2_phase", os_phase, 0);
    check("rst2_ready", cfg_ready, 1);
    reset = 1'b0;
    wait_tick(n);
    check("rst2_first_period", n, 651);
    wait_tick(n);
    check("rst2_second_period", n, 651);
    check("rst2_phase_after", os_phase, 2);

    // divisor 0 behaves as 1: back-to-back ticks
    load_frozen(0, 0);
    en = 1'b1;
    tick();
    check("div0_tick1", os_tick, 1);
    tick();
    check("div0_tick2", os_tick, 1);
    tick();
    check("div0_phase", os_phase, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART datapath: it divides the system clock into single-cycle oversample ticks and bit ticks. It replaces the fixed divide-by-constant toggling baud clock with the following:
- a runtime-loadable integer + fractional divisor;
- an oversample phase counter;
- a mid-bit strobe for RX sampling;
- a resync input for start-bit alignment.

It sits between the 100 MHz clock domain logic and the UART TX/RX FSMs, which consume its tick strobes as clock enables, not as clocks.

## Interface
Parameters:
- DIV_W, 16, width of integer divisor.
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle).
- OVERSAMPLE, 16, oversample ticks per bit; power of two, ≥4.
- DEFAULT_DIV_INT, 651, integer divisor after reset (100 MHz / 9600 / 16 = 651.04).
- DEFAULT_DIV_FRAC, 1, fractional divisor after reset.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low, all counters freeze.
- resync  in  1  one-cycle pulse; restarts the period and phase at zero.
- cfg_valid  in  1  a new divisor is offered.
- cfg_ready  out  1  the shadow divisor register is free.
- cfg_div_int  in  DIV_W  new integer divisor.
- cfg_div_frac  in  FRAC_W  new fractional divisor.
- os_tick  out  1  one-cycle oversample strobe.
- mid_tick  out  1  one-cycle strobe at the mid-bit phase.
- bit_tick  out  1  one-cycle strobe at the bit boundary.
- os_phase  out  $clog2(OVERSAMPLE)  current oversample phase.

## Operation
Registers:
- Active divisor: `act_int`, `act_frac`.
- Shadow divisor: `sh_int`, `sh_frac`, and `pending`.
- Period counter `cnt`, DIV_W bits.
- Fractional accumulator `acc`, FRAC_W bits.
- Phase counter `os_phase`.

Period length:
- At the start of every oversample period: {carry, acc_next} = acc + act_frac.
- Period length is len = eff_int + carry, where eff_int = max(act_int, 1).
- acc <= acc_next is committed when the period ends.
- Period is never 0: a divisor of 0 behaves as 1.

Counting:
- While en=1, cnt increments each cycle.
- When cnt == len-1: on the next edge cnt <= 0, os_tick <= 1, and os_phase <= os_phase+1 (wraps modulo OVERSAMPLE).
- mid_tick <= 1 together with os_tick when the old os_phase == OVERSAMPLE/2-1.
- bit_tick <= 1 together with os_tick when the old os_phase == OVERSAMPLE-1.
- Result: the average os_tick period is act_int + act_frac/2^FRAC_W cycles.

Enable:
- en=0 holds cnt, acc and os_phase.
- All tick outputs are 0 in the cycle after en is sampled low.

Resync:
- resync=1 sets cnt, acc and os_phase to 0 and drives all ticks to 0 on the next edge.
- resync has priority over en and over a period end in the same cycle.

Configuration handshake:
- A transfer occurs when cfg_valid && cfg_ready. It loads the shadow registers and sets pending.
- cfg_ready = !pending.
- The shadow is copied to active, and pending is cleared, on either of:
  - the edge that ends a period (os_tick being asserted), or
  - any edge with en=0 or resync=1.
- The new divisor applies from the next period; acc is not cleared by a divisor change.

Reset:
- cnt=0, acc=0, os_phase=0, os_tick=mid_tick=bit_tick=0.
- pending=0, cfg_ready=1.
- act_int/act_frac = DEFAULT_DIV_INT/DEFAULT_DIV_FRAC.
- Reset mid-period or mid-handshake discards any pending divisor.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- First os_tick occurs exactly len enabled cycles after reset deasserts (or after resync, or after en rises from the frozen state at cnt=0).
- Tick pulse width is always exactly 1 cycle. Ticks are never asserted in consecutive cycles unless len=1.
- bit_tick period is OVERSAMPLE × average len.
- mid_tick precedes bit_tick by OVERSAMPLE/2 os_ticks.
- cfg_ready falls 1 cycle after an accepted transfer and rises in the cycle after the swap.
- A cfg transfer in the same cycle as a period end is accepted into the shadow and applied at the following period end. It is not applied at the current one.

## Configuration
- BAUD_FRAC_EN defined: fractional accumulator, cfg_div_frac and act_frac are implemented as described above.
- BAUD_FRAC_EN undefined:
  - acc and act_frac are removed and carry is fixed at 0, so len = eff_int.
  - cfg_div_frac is ignored, and DEFAULT_DIV_FRAC is unused.
  - Ports stay the same.

## Test plan
- Integer divide, frac=0: cfg int=4, frac=0, en=1 -> os_tick every 4 cycles; bit_tick every 64 cycles; mid_tick 32 cycles before each bit_tick.
- Fractional divide: int=4, frac=8 with BAUD_FRAC_EN -> periods alternate 4,5,4,5, giving 16 os_ticks in 72 cycles. Without the macro -> 16 os_ticks in 64 cycles.
- Enable freeze: drop en for 10 cycles mid-period -> os_tick is delayed by exactly 10 cycles and os_phase is unchanged.
- Resync priority: pulse resync in the same cycle as a period end -> no os_tick that cycle; os_phase=0; next os_tick comes len cycles later.
- Config handshake: with int=4, offer int=6 mid-period -> cfg_ready low until the next os_tick; subsequent periods are 6 cycles; a second offer stalls until the swap.
- Reset defaults: assert reset mid-operation -> all ticks 0, os_phase=0, cfg_ready=1; with en=1, first os_tick occurs 651 cycles after reset deasserts.
